// File: rtl/mmio_bus_master.sv
// Autonomous MMIO bus initiator: queues read/write commands and replays them on the bus.
// Latency: write pulse on the edge after accept, read data sampled READ_LATENCY edges after address drive.
// Backpressure: cmd_ready drops when the command FIFO is full; a pending response stalls issue until rsp_ready.
module mmio_bus_master #(
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [12:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [12:0] rsp_addr,
  output logic [12:0] bus_address,
  output logic [31:0] bus_wdata,
  output logic        bus_wren,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITE     = 2'd1;
  localparam logic [1:0] S_READ_WAIT = 2'd2;
  localparam logic [1:0] S_RESP      = 2'd3;

  typedef struct packed {
    logic        wr;
    logic [12:0] addr;
    logic [31:0] data;
  } cmd_t;

  cmd_t          fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wren_q, wren_d;
  logic [12:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [12:0] rsp_addr_q, rsp_addr_d;

  logic full, empty, push, pop;
  cmd_t head;

  // Full refuses a push even when the head is leaving this cycle; an entry
  // pushed into an empty FIFO is only visible to the FSM after the edge.
  always_comb begin
    full  = (count_q == CW'(FIFO_DEPTH));
    empty = (count_q == '0);
    push  = cmd_valid && !full;
    pop   = (state_q == S_IDLE) && !empty;
    head  = fifo_q[rd_ptr_q];
  end

  // Occupancy tracking kept in its own counter so full/empty need no pointer compare.
  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (!push && pop)
      count_d = count_q - CW'(1);
  end

  // Command storage; contents are discarded on reset by clearing the pointers.
  always_ff @(posedge clock) begin
    if (push)
      fifo_q[wr_ptr_q] <= '{wr: cmd_write, addr: cmd_addr, data: cmd_data};
  end

  // FIFO pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Bus sequencer: one command at a time, strictly ordered, response must drain before the next issue.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wren_d      = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          addr_d = head.addr;
          if (head.wr) begin
            wdata_d = head.data;
            wren_d  = 1'b1;
            state_d = S_WRITE;
          end else begin
            cnt_d   = LAT;
            state_d = S_READ_WAIT;
          end
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      S_READ_WAIT: begin
        if (cnt_q == 3'd1) begin
          rsp_data_d  = bus_rdata;
          rsp_addr_d  = addr_q;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer and bus-facing registers; reset also cuts short any write pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  assign cmd_ready   = !full;
  assign busy        = !empty || (state_q != S_IDLE);
  assign bus_address = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_wren    = wren_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_addr    = rsp_addr_q;

endmodule
